// File: rtl/vga_frame_monitor.sv
// VGA stream checker: validates sync timing, locks onto the frame structure,
// counts clean frames and signs the visible pixels of each frame with CRC-16-CCITT.
`timescale 1ns/1ps

module vga_frame_monitor #(
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter int RGB_W           = 3,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int FRAME_CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   h_sync,
   input  logic                   v_sync,
   input  logic [RGB_W-1:0]       rgb,
   input  logic                   clr_err,
   output logic                   locked,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic [15:0]            signature,
   output logic                   sig_valid,
   output logic                   h_err,
   output logic                   v_err,
   output logic [7:0]             err_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HCNT_W  = $clog2(H_TOTAL + 1);
   localparam int VCNT_W  = $clog2(V_TOTAL + 1);

   localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
   localparam logic [HCNT_W-1:0] H_SAT    = HCNT_W'(H_TOTAL);
   localparam logic [HCNT_W-1:0] H_PULSE  = HCNT_W'(H_SYNC - 1);
   localparam logic [HCNT_W-1:0] H_VIS_LO = HCNT_W'(H_SYNC + H_BACK);
   localparam logic [HCNT_W-1:0] H_VIS_HI = HCNT_W'(H_SYNC + H_BACK + H_VISIBLE);
   localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
   localparam logic [VCNT_W-1:0] V_SAT    = VCNT_W'(V_TOTAL);
   localparam logic [VCNT_W-1:0] V_PULSE  = VCNT_W'(V_SYNC - 1);
   localparam logic [VCNT_W-1:0] V_VIS_LO = VCNT_W'(V_SYNC + V_BACK);
   localparam logic [VCNT_W-1:0] V_VIS_HI = VCNT_W'(V_SYNC + V_BACK + V_VISIBLE);
   localparam logic [15:0]       CRC_INIT = 16'hFFFF;

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                            input logic [RGB_W-1:0] data);
      logic [15:0] crc;
      crc = crc_in;
      for (int i = RGB_W - 1; i >= 0; i--)
         crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ data[i]) ? 16'h1021 : 16'h0000);
      return crc;
   endfunction

   state_t             state;
   logic               hs_q, hs_p, vs_q, vs_lead_q, vchk_pend;
   logic [RGB_W-1:0]   rgb_q;
   logic [HCNT_W-1:0]  hcnt;
   logic [VCNT_W-1:0]  vcnt;
   logic [15:0]        crc;
   logic               hs_norm, vs_norm, h_lead, h_trail, v_start, checking, visible;
   logic               h_fault, v_fault, err_h, err_v, err_any;

   assign hs_norm  = (SYNC_ACTIVE_LOW != 0) ? ~h_sync : h_sync;
   assign vs_norm  = (SYNC_ACTIVE_LOW != 0) ? ~v_sync : v_sync;
   assign h_lead   = hs_q & ~hs_p;
   assign h_trail  = ~hs_q & hs_p;
   assign v_start  = h_lead & vs_q & ~vs_lead_q;
   assign checking = (state != SEARCH);
   assign visible  = (hcnt >= H_VIS_LO) && (hcnt < H_VIS_HI) &&
                     (vcnt >= V_VIS_LO) && (vcnt < V_VIS_HI);
   assign err_h    = checking & h_fault;
   assign err_v    = checking & v_fault;
   assign err_any  = err_h | err_v;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hs_q  <= 1'b0;
         hs_p  <= 1'b0;
         vs_q  <= 1'b0;
         rgb_q <= '0;
      end else begin
         hs_q  <= hs_norm;
         hs_p  <= hs_q;
         vs_q  <= vs_norm;
         rgb_q <= rgb;
      end
   end

   // vsync level is remembered per line so a frame starts only on its first asserted line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcnt      <= '0;
         vcnt      <= '0;
         vs_lead_q <= 1'b0;
         vchk_pend <= 1'b0;
      end else begin
         if (h_lead)
            hcnt <= '0;
         else if (hcnt != H_SAT)
            hcnt <= hcnt + HCNT_W'(1);
         if (h_lead) begin
            vs_lead_q <= vs_q;
            if (v_start)
               vcnt <= '0;
            else if (vcnt != V_SAT)
               vcnt <= vcnt + VCNT_W'(1);
         end
         if (v_start)
            vchk_pend <= 1'b1;
         else if (h_lead && !vs_q)
            vchk_pend <= 1'b0;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      h_fault = 1'b0;
      v_fault = 1'b0;
      if (h_lead && hcnt != H_LAST)   h_fault = 1'b1;
      if (h_trail && hcnt != H_PULSE) h_fault = 1'b1;
      if (!h_lead && hcnt == H_LAST)  h_fault = 1'b1;
      if (v_start && vcnt != V_LAST)  v_fault = 1'b1;
      // vcnt still holds the previous line here, so V_SYNC-1 means the pulse was V_SYNC lines
      if (h_lead && !vs_q && vchk_pend && vcnt != V_PULSE) v_fault = 1'b1;
      if (h_lead && !v_start && vcnt == V_LAST)            v_fault = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= SEARCH;
         crc         <= CRC_INIT;
         locked      <= 1'b0;
         frame_count <= '0;
         signature   <= '0;
         sig_valid   <= 1'b0;
      end else begin
         sig_valid <= 1'b0;
         case (state)
            SEARCH: begin
               if (v_start) begin
                  state <= ACQUIRE;
                  crc   <= CRC_INIT;
               end
            end
            ACQUIRE, LOCKED: begin
               if (err_any) begin
                  state  <= SEARCH;
                  locked <= 1'b0;
               end else if (v_start) begin
                  // any error already dropped us to SEARCH, so reaching here means a clean frame
                  state       <= LOCKED;
                  locked      <= 1'b1;
                  signature   <= crc;
                  sig_valid   <= 1'b1;
                  frame_count <= frame_count + FRAME_CNT_W'(1);
                  crc         <= CRC_INIT;
               end else if (visible) begin
                  crc <= crc_step(crc, rgb_q);
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

   // A detected error outranks a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_err     <= 1'b0;
         v_err     <= 1'b0;
         err_count <= '0;
      end else begin
         h_err <= err_h | (h_err & ~clr_err);
         v_err <= err_v | (v_err & ~clr_err);
         if (err_any)
            err_count <= clr_err ? 8'd1 : ((err_count == 8'hFF) ? err_count : err_count + 8'd1);
         else if (clr_err)
            err_count <= '0;
      end
   end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a tiny 14x7 raster: lock, signatures,
// timing errors, error counter saturation, async reset and an active-high/2-bit-counter variant.
`timescale 1ns/1ps

module tb_vga_frame_monitor;

   localparam int HV = 8, HF = 2, HS = 2, HB = 2;
   localparam int VV = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;

   logic clk = 1'b0, reset = 1'b0, clr_err = 1'b0;
   logic h_act = 1'b0, v_act = 1'b0;
   logic [2:0] rgb = 3'd0;
   logic h_sync_lo, v_sync_lo;
   assign h_sync_lo = ~h_act;
   assign v_sync_lo = ~v_act;

   logic        locked_a, sv_a, herr_a, verr_a;
   logic [15:0] fc_a, sig_a;
   logic [7:0]  ec_a;
   logic        locked_b, sv_b, herr_b, verr_b;
   logic [1:0]  fc_b;
   logic [15:0] sig_b;
   logic [7:0]  ec_b;

   vga_frame_monitor #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .RGB_W(3), .SYNC_ACTIVE_LOW(1), .FRAME_CNT_W(16)
   ) dut_a (
      .clk(clk), .reset(reset), .h_sync(h_sync_lo), .v_sync(v_sync_lo), .rgb(rgb),
      .clr_err(clr_err), .locked(locked_a), .frame_count(fc_a), .signature(sig_a),
      .sig_valid(sv_a), .h_err(herr_a), .v_err(verr_a), .err_count(ec_a)
   );

   vga_frame_monitor #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .RGB_W(3), .SYNC_ACTIVE_LOW(0), .FRAME_CNT_W(2)
   ) dut_b (
      .clk(clk), .reset(reset), .h_sync(h_act), .v_sync(v_act), .rgb(rgb),
      .clr_err(clr_err), .locked(locked_b), .frame_count(fc_b), .signature(sig_b),
      .sig_valid(sv_b), .h_err(herr_b), .v_err(verr_b), .err_count(ec_b)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Monitor: cycle counter, signature log and first lock time.
   int          cyc = 0;
   int          lock_cyc = -1;
   logic [15:0] sig_q[$];
   logic [15:0] fc_q[$];
   logic [1:0]  fc2_q[$];
   int          start_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sv_a) begin
         sig_q.push_back(sig_a);
         fc_q.push_back(fc_a);
      end
      if (sv_b) fc2_q.push_back(fc_b);
      if (locked_a && lock_cyc < 0) lock_cyc <= cyc;
   end

   logic [15:0] mcrc = 16'hFFFF;

   function automatic logic [15:0] crc_px(input logic [15:0] c_in, input logic [2:0] d);
      logic [15:0] c;
      logic        fb;
      c = c_in;
      for (int i = 2; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = c << 1;
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   task automatic pix(input logic hs, input logic vs, input logic [2:0] c, input logic clr);
      @(posedge clk);
      #1;
      h_act   = hs;
      v_act   = vs;
      rgb     = c;
      clr_err = clr;
   endtask

   // The monitor's horizontal count restarts on the registered sync edge, so line
   // position p is seen as hcnt = p-1; the reference CRC uses that window.
   task automatic line(input int l, input logic vs, input int hs_w, input int len,
                       input logic ramp, input int flip_p, input int clr_p);
      for (int p = 0; p < len; p++) begin
         logic [2:0] c;
         c = ramp ? 3'(p + l) : 3'd0;
         if (p == flip_p) c = c ^ 3'b001;
         pix(p < hs_w, vs, c, p == clr_p);
         if (l == 0 && p == 0) start_q.push_back(cyc);
         if (p - 1 >= HS + HB && p - 1 < HS + HB + HV && l >= VS + VB && l < VS + VB + VV)
            mcrc = crc_px(mcrc, c);
      end
   endtask

   task automatic frame(input logic ramp, input logic no_vs, input int l3_w, input int l3_len,
                        input int l3_flip, input int l3_clr, input int first, input int last);
      if (first == 0) mcrc = 16'hFFFF;
      for (int l = first; l <= last; l++) begin
         if (l == 3) line(l, 1'b0, l3_w, l3_len, ramp, l3_flip, l3_clr);
         else        line(l, (l < VS) && !no_vs, HS, HT, ramp, -1, -1);
      end
   endtask

   task automatic clean_frame(input logic ramp);
      frame(ramp, 1'b0, HS, HT, -1, -1, 0, VT - 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   logic [15:0] m_zero, m_a, m_b, m_c, m_r1;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      check("rst_a", {locked_a, fc_a, sig_a, sv_a, herr_a, verr_a, ec_a}, 64'd0);
      check("rst_b", {locked_b, fc_b, sig_b, sv_b, herr_b, verr_b, ec_b}, 64'd0);
      @(negedge clk) reset = 1'b1;
      repeat (4) pix(1'b0, 1'b0, 3'd0, 1'b0);

      // Ideal frames, rgb = 0
      for (int k = 0; k < 6; k++) begin
         clean_frame(1'b0);
         if (k == 0) m_zero = mcrc;
      end
      check("lock_latency", 64'(lock_cyc - start_q[1]), 64'd2);
      check("sig_pulses", sig_q.size(), 5);
      check("fc_1", fc_q[0], 1);
      check("fc_2", fc_q[1], 2);
      check("fc_3", fc_q[2], 3);
      check("sig_zero", sig_q[0], m_zero);
      check("clean_errs", {herr_a, verr_a, ec_a}, 0);
      check("b_locked", locked_b, 1);
      check("b_fc_1", fc2_q[0], 1);
      check("b_fc_2", fc2_q[1], 2);
      check("b_fc_3", fc2_q[2], 3);
      check("b_fc_wrap", fc2_q[3], 0);
      check("b_fc_5", fc2_q[4], 1);

      // Ramp frames; third one has a single flipped pixel
      sig_q.delete();
      clean_frame(1'b1);
      m_a = mcrc;
      clean_frame(1'b1);
      m_b = mcrc;
      frame(1'b1, 1'b0, HS, HT, 7, -1, 0, VT - 1);
      m_c = mcrc;
      clean_frame(1'b1);
      check("ramp_pulses", sig_q.size(), 4);
      check("sig_a", sig_q[1], m_a);
      check("sig_b", sig_q[2], m_b);
      check("sig_repeat", sig_q[2], sig_q[1]);
      check("sig_flip", sig_q[3], m_c);
      check("sig_flip_diff", sig_q[3] != sig_q[2], 1);

      // 3-clock hsync while locked
      frame(1'b0, 1'b0, 3, HT, -1, -1, 0, VT - 1);
      check("wide_herr", herr_a, 1);
      check("wide_verr", verr_a, 0);
      check("wide_cnt", ec_a, 1);
      check("wide_unlock", locked_a, 0);
      clean_frame(1'b0);
      clean_frame(1'b0);
      check("relock", locked_a, 1);
      check("herr_sticky", herr_a, 1);
      frame(1'b0, 1'b0, HS, HT, -1, 5, 0, VT - 1);
      check("clr_flags", {herr_a, verr_a, ec_a}, 0);
      check("clr_keeps_lock", locked_a, 1);
      check("clr_keeps_fc", fc_a, 12);

      // Line one clock too long
      frame(1'b0, 1'b0, HS, HT + 1, -1, -1, 0, VT - 1);
      check("long_herr", herr_a, 1);
      check("long_verr", verr_a, 0);
      clean_frame(1'b0);
      clean_frame(1'b0);
      frame(1'b0, 1'b0, HS, HT, -1, 5, 0, VT - 1);
      check("pre_novs", {locked_a, herr_a, verr_a}, 3'b100);

      // Missing vsync for a whole frame
      frame(1'b0, 1'b1, HS, HT, -1, -1, 0, VT - 1);
      check("novs_verr", verr_a, 1);
      check("novs_herr", herr_a, 0);

      // 300 error events: frame start, then a wide hsync
      for (int k = 0; k < 300; k++) begin
         line(0, 1'b1, HS, HT, 1'b0, -1, -1);
         line(1, 1'b0, 3, HT, 1'b0, -1, -1);
      end
      check("cnt_sat", ec_a, 255);
      line(0, 1'b1, HS, HT, 1'b0, -1, -1);
      line(1, 1'b0, 3, HT, 1'b0, -1, 4);
      check("err_wins_cnt", ec_a, 1);
      check("err_wins_flag", herr_a, 1);

      // Async reset in the middle of a locked frame
      clean_frame(1'b0);
      clean_frame(1'b0);
      frame(1'b0, 1'b0, HS, HT, -1, -1, 0, 2);
      check("pre_reset_lock", locked_a, 1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_a", {locked_a, fc_a, sig_a, sv_a, herr_a, verr_a, ec_a}, 64'd0);
      check("async_rst_b", {locked_b, fc_b, sig_b, sv_b, herr_b, verr_b, ec_b}, 64'd0);
      sig_q.delete();
      fc_q.delete();
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      frame(1'b0, 1'b0, HS, HT, -1, -1, 3, VT - 1);
      clean_frame(1'b1);
      m_r1 = mcrc;
      clean_frame(1'b1);
      check("post_rst_pulses", sig_q.size(), 1);
      check("post_rst_fc", fc_q[0], 1);
      check("post_rst_sig", sig_q[0], m_r1);
      check("post_rst_lock", locked_a, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
